// File: rtl/tnn_infer_ctrl.sv
// Sequencer for a combinational TNN classifier: assembles serial feature beats,
// waits for the classifier to settle, scores the prediction and emits each result.
module tnn_infer_ctrl #(
  parameter int FEAT_CNT  = 12,
  parameter int FEAT_BITS = 4,
  parameter int CLASS_CNT = 6,
  parameter int TEST_CNT  = 1000,
  parameter int CLS_LAT   = 0,
  localparam int LBL_W    = $clog2(CLASS_CNT),
  localparam int CNT_W    = $clog2(TEST_CNT + 1)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [FEAT_BITS-1:0]          in_data,
  input  logic [LBL_W-1:0]              in_label,
  output logic [FEAT_CNT*FEAT_BITS-1:0] features,
  input  logic [LBL_W-1:0]              prediction,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [LBL_W-1:0]              out_pred,
  output logic                          out_hit,
  output logic [CNT_W-1:0]              sample_idx,
  output logic [CNT_W-1:0]              correct_cnt,
  output logic                          busy,
  output logic                          done
);

  localparam int FIDX_W = (FEAT_CNT > 1) ? $clog2(FEAT_CNT) : 1;
  localparam int WCNT_W = (CLS_LAT > 0) ? $clog2(CLS_LAT + 1) : 1;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    WAIT = 3'd2,
    EMIT = 3'd3,
    DONE = 3'd4
  } state_t;

  state_t                        state_q, state_d;
  logic [FIDX_W-1:0]             feat_idx_q, feat_idx_d;
  logic [WCNT_W-1:0]             wait_cnt_q, wait_cnt_d;
  logic [FEAT_CNT*FEAT_BITS-1:0] features_q, features_d;
  logic [LBL_W-1:0]              label_q, label_d;
  logic [LBL_W-1:0]              out_pred_q, out_pred_d;
  logic                          out_hit_q, out_hit_d;
  logic [CNT_W-1:0]              sample_idx_q, sample_idx_d;
  logic [CNT_W-1:0]              correct_cnt_q, correct_cnt_d;
  logic                          hit;

  assign hit = (prediction == label_q);

  always_comb begin
    state_d       = state_q;
    feat_idx_d    = feat_idx_q;
    wait_cnt_d    = wait_cnt_q;
    features_d    = features_q;
    label_d       = label_q;
    out_pred_d    = out_pred_q;
    out_hit_d     = out_hit_q;
    sample_idx_d  = sample_idx_q;
    correct_cnt_d = correct_cnt_q;

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d       = LOAD;
          sample_idx_d  = '0;
          correct_cnt_d = '0;
          feat_idx_d    = '0;
        end
      end
      LOAD: begin
        if (in_valid) begin
          for (int i = 0; i < FEAT_CNT; i++) begin
            if (feat_idx_q == FIDX_W'(i)) begin
              features_d[i*FEAT_BITS +: FEAT_BITS] = in_data;
            end
          end
          if (feat_idx_q == FIDX_W'(FEAT_CNT - 1)) begin
            label_d    = in_label;
            feat_idx_d = '0;
            wait_cnt_d = WCNT_W'(CLS_LAT);
            state_d    = WAIT;
          end else begin
            feat_idx_d = feat_idx_q + FIDX_W'(1);
          end
        end
      end
      WAIT: begin
        // The label was captured with the last beat, so prediction is scored here.
        if (wait_cnt_q == '0) begin
          out_pred_d = prediction;
          out_hit_d  = hit;
          if (hit) begin
            correct_cnt_d = correct_cnt_q + CNT_W'(1);
          end
          state_d = EMIT;
        end else begin
          wait_cnt_d = wait_cnt_q - WCNT_W'(1);
        end
      end
      EMIT: begin
        if (out_ready) begin
          if (sample_idx_q == CNT_W'(TEST_CNT - 1)) begin
            state_d = DONE;
          end else begin
            sample_idx_d = sample_idx_q + CNT_W'(1);
            state_d      = LOAD;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      feat_idx_q    <= '0;
      wait_cnt_q    <= '0;
      features_q    <= '0;
      label_q       <= '0;
      out_pred_q    <= '0;
      out_hit_q     <= 1'b0;
      sample_idx_q  <= '0;
      correct_cnt_q <= '0;
    end else begin
      state_q       <= state_d;
      feat_idx_q    <= feat_idx_d;
      wait_cnt_q    <= wait_cnt_d;
      features_q    <= features_d;
      label_q       <= label_d;
      out_pred_q    <= out_pred_d;
      out_hit_q     <= out_hit_d;
      sample_idx_q  <= sample_idx_d;
      correct_cnt_q <= correct_cnt_d;
    end
  end

  assign in_ready    = (state_q == LOAD);
  assign out_valid   = (state_q == EMIT);
  assign busy        = (state_q == LOAD) || (state_q == WAIT) || (state_q == EMIT);
  assign done        = (state_q == DONE);
  assign features    = features_q;
  assign out_pred    = out_pred_q;
  assign out_hit     = out_hit_q;
  assign sample_idx  = sample_idx_q;
  assign correct_cnt = correct_cnt_q;

endmodule

// File: tb/tb_tnn_infer_ctrl.sv
// Bench for tnn_infer_ctrl: a zero-latency instance with a feature[0] mod 6 stub and a
// CLS_LAT=2 instance with a two-stage registered stub, both checked against a sample model.
module tb_tnn_infer_ctrl;

  localparam int FC = 12;
  localparam int FB = 4;

  typedef logic [FB-1:0] feat_t [FC];

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic              start_s     [2];
  logic              in_valid_s  [2];
  logic              in_ready_s  [2];
  logic [FB-1:0]     in_data_s   [2];
  logic [2:0]        in_label_s  [2];
  logic [FC*FB-1:0]  features_s  [2];
  logic [2:0]        pred_s      [2];
  logic              out_valid_s [2];
  logic              out_ready_s [2];
  logic [2:0]        out_pred_s  [2];
  logic              out_hit_s   [2];
  logic [1:0]        sample_idx_s[2];
  logic [1:0]        correct_s   [2];
  logic              busy_s      [2];
  logic              done_s      [2];

  int checks = 0;
  int errors = 0;

  feat_t mfeat   [2];
  int    midx    [2];
  int    mcorrect[2];

  tnn_infer_ctrl #(.TEST_CNT(3), .CLS_LAT(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start_s[0]),
    .in_valid(in_valid_s[0]), .in_ready(in_ready_s[0]), .in_data(in_data_s[0]),
    .in_label(in_label_s[0]), .features(features_s[0]), .prediction(pred_s[0]),
    .out_valid(out_valid_s[0]), .out_ready(out_ready_s[0]), .out_pred(out_pred_s[0]),
    .out_hit(out_hit_s[0]), .sample_idx(sample_idx_s[0]), .correct_cnt(correct_s[0]),
    .busy(busy_s[0]), .done(done_s[0])
  );

  tnn_infer_ctrl #(.TEST_CNT(3), .CLS_LAT(2)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start_s[1]),
    .in_valid(in_valid_s[1]), .in_ready(in_ready_s[1]), .in_data(in_data_s[1]),
    .in_label(in_label_s[1]), .features(features_s[1]), .prediction(pred_s[1]),
    .out_valid(out_valid_s[1]), .out_ready(out_ready_s[1]), .out_pred(out_pred_s[1]),
    .out_hit(out_hit_s[1]), .sample_idx(sample_idx_s[1]), .correct_cnt(correct_s[1]),
    .busy(busy_s[1]), .done(done_s[1])
  );

  // Stub classifiers: combinational for dut0, two register stages for dut1.
  logic [2:0] p1 = 3'd0;
  logic [2:0] p2 = 3'd0;
  assign pred_s[0] = 3'(features_s[0][3:0] % 4'd6);
  always @(posedge clk) begin
    p1 <= 3'((5'(features_s[1][3:0]) + 5'(features_s[1][47:44])) % 5'd6);
    p2 <= p1;
  end
  assign pred_s[1] = p2;

  function automatic logic [2:0] model_pred(input int d, input feat_t f);
    if (d == 0) return 3'(int'(f[0]) % 6);
    return 3'((int'(f[0]) + int'(f[FC-1])) % 6);
  endfunction

  function automatic logic [FC*FB-1:0] model_bus(input feat_t f);
    logic [FC*FB-1:0] b;
    b = '0;
    for (int i = 0; i < FC; i++) b[i*FB +: FB] = f[i];
    return b;
  endfunction

  task automatic rand_feats(output feat_t f);
    for (int i = 0; i < FC; i++) f[i] = 4'($urandom_range(0, 15));
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic pulse_start(input int d);
    start_s[d] = 1'b1;
    step();
    start_s[d] = 1'b0;
  endtask

  // Loads one sample, waits for the result and checks it against the model.
  task automatic do_sample(input int d, input feat_t f, input logic [2:0] label, input bit gaps);
    int cnt;
    int lat;
    logic [2:0] ep;
    logic eh;
    for (int i = 0; i < FC; i++) begin
      if (gaps && ($urandom_range(0, 2) == 0)) begin
        in_valid_s[d] = 1'b0;
        in_data_s[d]  = 4'($urandom_range(0, 15));
        step();
      end
      in_valid_s[d] = 1'b1;
      in_data_s[d]  = f[i];
      in_label_s[d] = (i == FC-1) ? label : 3'($urandom_range(0, 5));
      step();
      mfeat[d][i] = f[i];
    end
    in_valid_s[d] = 1'b0;
    lat = (d == 0) ? 0 : 2;
    cnt = 0;
    while (!out_valid_s[d] && cnt < 20) begin
      checks++;
      if (in_ready_s[d] !== 1'b0) begin
        errors++;
        $display("[TB] FAIL wait_in_ready dut%0d: got %b expected 0", d, in_ready_s[d]);
      end
      step();
      cnt++;
    end
    checks++;
    if (cnt !== lat + 1) begin
      errors++;
      $display("[TB] FAIL latency dut%0d: got %0d cycles after last-beat edge expected %0d", d, cnt, lat + 1);
    end
    ep = model_pred(d, mfeat[d]);
    eh = (ep == label);
    if (eh) mcorrect[d]++;
    checks++;
    if (features_s[d] !== model_bus(mfeat[d])) begin
      errors++;
      $display("[TB] FAIL features dut%0d: got %h expected %h", d, features_s[d], model_bus(mfeat[d]));
    end
    checks++;
    if (out_pred_s[d] !== ep) begin
      errors++;
      $display("[TB] FAIL out_pred dut%0d: got %0d expected %0d", d, out_pred_s[d], ep);
    end
    checks++;
    if (out_hit_s[d] !== eh) begin
      errors++;
      $display("[TB] FAIL out_hit dut%0d: got %b expected %b", d, out_hit_s[d], eh);
    end
    checks++;
    if (correct_s[d] !== 2'(mcorrect[d])) begin
      errors++;
      $display("[TB] FAIL correct_cnt dut%0d: got %0d expected %0d", d, correct_s[d], mcorrect[d]);
    end
    checks++;
    if (sample_idx_s[d] !== 2'(midx[d]) || in_ready_s[d] !== 1'b0 || busy_s[d] !== 1'b1) begin
      errors++;
      $display("[TB] FAIL emit_status dut%0d: got idx=%0d in_ready=%b busy=%b expected idx=%0d in_ready=0 busy=1",
               d, sample_idx_s[d], in_ready_s[d], busy_s[d], midx[d]);
    end
  endtask

  task automatic handshake(input int d);
    bit last;
    out_ready_s[d] = 1'b1;
    step();
    out_ready_s[d] = 1'b0;
    last = (midx[d] == 2);
    if (!last) midx[d]++;
    checks++;
    if (out_valid_s[d] !== 1'b0) begin
      errors++;
      $display("[TB] FAIL out_valid_drop dut%0d: got %b expected 0", d, out_valid_s[d]);
    end
    checks++;
    if (done_s[d] !== last || in_ready_s[d] !== !last || sample_idx_s[d] !== 2'(midx[d])) begin
      errors++;
      $display("[TB] FAIL after_handshake dut%0d: got done=%b in_ready=%b idx=%0d expected done=%b in_ready=%b idx=%0d",
               d, done_s[d], in_ready_s[d], sample_idx_s[d], last, !last, midx[d]);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int d = 0; d < 2; d++) begin
      start_s[d] = 1'b0; in_valid_s[d] = 1'b0; in_data_s[d] = '0;
      in_label_s[d] = '0; out_ready_s[d] = 1'b0;
      midx[d] = 0; mcorrect[d] = 0;
      for (int i = 0; i < FC; i++) mfeat[d][i] = '0;
    end
    step(); step();
    for (int d = 0; d < 2; d++) begin
      checks++;
      if ({features_s[d], out_pred_s[d], out_hit_s[d], sample_idx_s[d], correct_s[d]} !== '0) begin
        errors++;
        $display("[TB] FAIL reset_data dut%0d: got features=%h pred=%0d hit=%b idx=%0d cnt=%0d expected all 0",
                 d, features_s[d], out_pred_s[d], out_hit_s[d], sample_idx_s[d], correct_s[d]);
      end
      checks++;
      if ({in_ready_s[d], out_valid_s[d], busy_s[d], done_s[d]} !== 4'b0000) begin
        errors++;
        $display("[TB] FAIL reset_ctrl dut%0d: got %b expected 0000",
                 d, {in_ready_s[d], out_valid_s[d], busy_s[d], done_s[d]});
      end
    end
    rst_n = 1'b1;
    step();
    in_valid_s[0] = 1'b1;
    step();
    in_valid_s[0] = 1'b0;
    checks++;
    if (busy_s[0] !== 1'b0 || features_s[0] !== '0) begin
      errors++;
      $display("[TB] FAIL idle_ignores_beat: got busy=%b features=%h expected 0", busy_s[0], features_s[0]);
    end
  endtask

  task automatic test_single();
    feat_t f;
    for (int i = 0; i < FC; i++) f[i] = '0;
    f[0] = 4'd4;
    pulse_start(0);
    checks++;
    if (busy_s[0] !== 1'b1 || in_ready_s[0] !== 1'b1 || correct_s[0] !== 2'd0) begin
      errors++;
      $display("[TB] FAIL start_load: got busy=%b in_ready=%b cnt=%0d expected 1 1 0",
               busy_s[0], in_ready_s[0], correct_s[0]);
    end
    do_sample(0, f, 3'd4, 1'b0);
    checks++;
    if (out_pred_s[0] !== 3'd4 || out_hit_s[0] !== 1'b1 || correct_s[0] !== 2'd1) begin
      errors++;
      $display("[TB] FAIL single_sample: got pred=%0d hit=%b cnt=%0d expected 4 1 1",
               out_pred_s[0], out_hit_s[0], correct_s[0]);
    end
    handshake(0);
  endtask

  task automatic test_backpressure();
    feat_t f;
    logic [2:0] ep;
    rand_feats(f);
    do_sample(0, f, 3'($urandom_range(0, 5)), 1'b0);
    ep = model_pred(0, mfeat[0]);
    for (int c = 0; c < 5; c++) begin
      out_ready_s[0] = 1'b0;
      in_valid_s[0]  = c[0];
      in_data_s[0]   = 4'($urandom_range(0, 15));
      step();
      checks++;
      if (out_valid_s[0] !== 1'b1 || out_pred_s[0] !== ep || in_ready_s[0] !== 1'b0 ||
          features_s[0] !== model_bus(mfeat[0])) begin
        errors++;
        $display("[TB] FAIL backpressure c%0d: got valid=%b pred=%0d in_ready=%b features=%h expected 1 %0d 0 %h",
                 c, out_valid_s[0], out_pred_s[0], in_ready_s[0], features_s[0], ep, model_bus(mfeat[0]));
      end
    end
    in_valid_s[0] = 1'b0;
    handshake(0);
  endtask

  task automatic test_start_ignored();
    feat_t f;
    pulse_start(0);
    checks++;
    if (sample_idx_s[0] !== 2'(midx[0]) || correct_s[0] !== 2'(mcorrect[0]) || in_ready_s[0] !== 1'b1) begin
      errors++;
      $display("[TB] FAIL start_in_load: got idx=%0d cnt=%0d in_ready=%b expected %0d %0d 1",
               sample_idx_s[0], correct_s[0], in_ready_s[0], midx[0], mcorrect[0]);
    end
    rand_feats(f);
    do_sample(0, f, model_pred(0, f), 1'b1);
    pulse_start(0);
    checks++;
    if (out_valid_s[0] !== 1'b1 || sample_idx_s[0] !== 2'(midx[0]) || correct_s[0] !== 2'(mcorrect[0])) begin
      errors++;
      $display("[TB] FAIL start_in_emit: got valid=%b idx=%0d cnt=%0d expected 1 %0d %0d",
               out_valid_s[0], sample_idx_s[0], correct_s[0], midx[0], mcorrect[0]);
    end
    handshake(0);
  endtask

  task automatic test_full_run();
    feat_t f;
    logic [2:0] p;
    logic [2:0] lbl;
    pulse_start(0);
    midx[0] = 0;
    mcorrect[0] = 0;
    checks++;
    if (sample_idx_s[0] !== 2'd0 || correct_s[0] !== 2'd0 || done_s[0] !== 1'b0 || busy_s[0] !== 1'b1) begin
      errors++;
      $display("[TB] FAIL restart_from_done: got idx=%0d cnt=%0d done=%b busy=%b expected 0 0 0 1",
               sample_idx_s[0], correct_s[0], done_s[0], busy_s[0]);
    end
    for (int s = 0; s < 3; s++) begin
      rand_feats(f);
      p = model_pred(0, f);
      lbl = (s == 1) ? 3'((int'(p) + $urandom_range(1, 5)) % 6) : p;
      do_sample(0, f, lbl, 1'b1);
      handshake(0);
    end
    checks++;
    if (done_s[0] !== 1'b1 || busy_s[0] !== 1'b0 || correct_s[0] !== 2'd2 || sample_idx_s[0] !== 2'd2) begin
      errors++;
      $display("[TB] FAIL run_complete: got done=%b busy=%b cnt=%0d idx=%0d expected 1 0 2 2",
               done_s[0], busy_s[0], correct_s[0], sample_idx_s[0]);
    end
    pulse_start(0);
    midx[0] = 0;
    mcorrect[0] = 0;
    checks++;
    if (correct_s[0] !== 2'd0 || sample_idx_s[0] !== 2'd0 || done_s[0] !== 1'b0) begin
      errors++;
      $display("[TB] FAIL done_restart_clear: got cnt=%0d idx=%0d done=%b expected 0 0 0",
               correct_s[0], sample_idx_s[0], done_s[0]);
    end
  endtask

  task automatic test_latency();
    feat_t f;
    logic [2:0] prev;
    int tries;
    pulse_start(1);
    prev = 3'd7;
    for (int s = 0; s < 3; s++) begin
      tries = 0;
      rand_feats(f);
      while (model_pred(1, f) == prev && tries < 50) begin
        rand_feats(f);
        tries++;
      end
      prev = model_pred(1, f);
      do_sample(1, f, 3'($urandom_range(0, 5)), s == 1);
      handshake(1);
    end
    checks++;
    if (done_s[1] !== 1'b1 || correct_s[1] !== 2'(mcorrect[1])) begin
      errors++;
      $display("[TB] FAIL lat_run_complete: got done=%b cnt=%0d expected 1 %0d",
               done_s[1], correct_s[1], mcorrect[1]);
    end
  endtask

  task automatic test_reset_mid_load();
    feat_t f;
    for (int i = 0; i < 6; i++) begin
      in_valid_s[0] = 1'b1;
      in_data_s[0]  = 4'($urandom_range(1, 15));
      step();
    end
    in_valid_s[0] = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({features_s[0], out_pred_s[0], out_hit_s[0], sample_idx_s[0], correct_s[0]} !== '0 ||
        {in_ready_s[0], out_valid_s[0], busy_s[0], done_s[0], done_s[1]} !== 5'b00000) begin
      errors++;
      $display("[TB] FAIL async_reset: got features=%h pred=%0d ctrl=%b expected all 0",
               features_s[0], out_pred_s[0],
               {in_ready_s[0], out_valid_s[0], busy_s[0], done_s[0], done_s[1]});
    end
    step();
    rst_n = 1'b1;
    midx[0] = 0;
    mcorrect[0] = 0;
    for (int i = 0; i < FC; i++) mfeat[0][i] = '0;
    step();
    pulse_start(0);
    rand_feats(f);
    do_sample(0, f, model_pred(0, f), 1'b1);
    handshake(0);
  endtask

  initial begin
    #300000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    test_reset();
    test_single();
    test_backpressure();
    test_start_ignored();
    test_full_run();
    test_latency();
    test_reset_mid_load();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/tnn_infer_ctrl.md
Name: tnn_infer_ctrl

Overview:
- Sequencer that drives one combinational TNN classifier (12×4-bit features in, 3-bit prediction out) over a test set of TEST_CNT samples.
- Accepts features serially, one per beat, and assembles them into the parallel feature bus.
- Waits a configurable settle latency, then samples the prediction and compares it with the sample label.
- Emits each result over a valid/ready handshake and keeps a running count of correct predictions until the set completes.

Parameters:
- FEAT_CNT, 12, features per sample.
- FEAT_BITS, 4, bits per feature.
- CLASS_CNT, 6, number of classes; prediction/label width is $clog2(CLASS_CNT).
- TEST_CNT, 1000, samples per run.
- CLS_LAT, 0, extra cycles to wait for the classifier output after the last feature is loaded (0 for purely combinational classifiers).

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  reset; asynchronous assert, active-low.
- start  input  1  one-cycle pulse; begins a run. Honoured only in IDLE or DONE.
- in_valid  input  1  serial feature beat valid.
- in_ready  output  1  controller accepts a feature beat.
- in_data  input  FEAT_BITS  feature value; feature 0 arrives first.
- in_label  input  $clog2(CLASS_CNT)  ground-truth class; sampled on the last feature beat of the sample.
- features  output  FEAT_CNT*FEAT_BITS  parallel bus to the classifier; feature i occupies [i*FEAT_BITS +: FEAT_BITS].
- prediction  input  $clog2(CLASS_CNT)  classifier result.
- out_valid  output  1  result available.
- out_ready  input  1  result consumer ready.
- out_pred  output  $clog2(CLASS_CNT)  registered prediction.
- out_hit  output  1  out_pred == captured label.
- sample_idx  output  $clog2(TEST_CNT+1)  index of the current sample.
- correct_cnt  output  $clog2(TEST_CNT+1)  hits so far in this run.
- busy  output  1  state is LOAD, WAIT or EMIT.
- done  output  1  high in DONE.

Behaviour:
- Reset values: state=IDLE; all outputs 0, including features, out_pred, out_hit, counters, in_ready, out_valid, busy and done. Reset mid-operation aborts the run immediately; no partial result is emitted.
- IDLE:
  - in_ready=0.
  - start → LOAD; clear sample_idx, correct_cnt and feat_idx.
- LOAD:
  - in_ready=1.
  - Each in_valid&&in_ready writes in_data into slot feat_idx and increments feat_idx. Other slots hold.
  - The beat with feat_idx==FEAT_CNT-1 also captures in_label and resets feat_idx to 0.
  - State → WAIT with wait_cnt=CLS_LAT.
- WAIT:
  - in_ready=0; features is stable.
  - If wait_cnt==0, the controller registers prediction into out_pred and sets out_hit=(prediction==label).
  - On that same edge, correct_cnt increments if hit; state → EMIT.
  - Otherwise wait_cnt decrements.
  - Latency from last feature beat to out_valid is CLS_LAT+2 cycles.
- EMIT:
  - out_valid=1; out_pred and out_hit are held stable until out_valid&&out_ready.
  - On handshake, if sample_idx==TEST_CNT-1 → DONE; otherwise sample_idx increments → LOAD.
  - out_valid drops the cycle after the handshake. There is no back-to-back emit, because the next sample needs at least FEAT_CNT beats.
- DONE:
  - done=1; sample_idx and correct_cnt hold the final values.
  - start → LOAD with counters cleared, same as from IDLE.
- start outside IDLE/DONE is ignored.
- in_valid outside LOAD is ignored; no data is consumed.
- features holds its last value in all states except LOAD slot writes. It is not cleared between samples.
- Counter widths never overflow: correct_cnt ≤ sample_idx+1 ≤ TEST_CNT.
- busy = state ∈ {LOAD, WAIT, EMIT}.

Test Plan:
- Defaults, stub prediction = feature[0] mod 6, one sample.
  - Stimulus: start, then 12 beats, feature0=4, others 0, label=4.
  - Required: out_valid exactly 2 cycles after the 12th beat; out_pred=4, out_hit=1, correct_cnt=1; in_ready=0 during WAIT/EMIT.
- Backpressure.
  - Stimulus: hold out_ready=0 for 5 cycles in EMIT, with in_valid toggling throughout.
  - Required: out_pred stable, in_ready=0, no beats consumed, features unchanged. Release → handshake → LOAD.
- TEST_CNT=3 run.
  - Stimulus: labels chosen so hits are 1, 0, 1.
  - Required: after the third handshake, done=1, busy=0, correct_cnt=2, sample_idx=2. A start in DONE clears the counters to 0.
- CLS_LAT=2 with a 2-cycle registered stub classifier.
  - Required: out_valid 4 cycles after the last beat; out_pred equals the stub output for that sample's features, not the previous sample's.
- Reset mid-LOAD.
  - Stimulus: assert rst_n=0 after 6 beats, asynchronously between edges.
  - Required: all outputs 0 immediately, state IDLE. After release and start, a full 12-beat sample yields correct results with no leftover feat_idx.
- start pulsed during LOAD and during EMIT.
  - Required: ignored; counters and state unaffected. in_valid gaps inside LOAD only stall feat_idx.
